// File: rtl/bytewrite_ram_req_ctrl.sv
// Request/response front end for a single-port, read-first byte-write RAM with a
// 1-cycle registered read; read data is parked in a response FIFO sized by credits.
module bytewrite_ram_req_ctrl #(
  parameter int NUM_COL    = 4,
  parameter int COL_WIDTH  = 8,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = NUM_COL * COL_WIDTH,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_rd,
  input  logic [NUM_COL-1:0]    req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  ram_ena,
  output logic [NUM_COL-1:0]    ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy
);

  localparam int PW = $clog2(RESP_DEPTH);

  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; valid must not depend on ready, and ready here depends on registers only.

  logic                  inflight;
  logic [PW:0]           occ;
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [DATA_WIDTH-1:0] fifo [RESP_DEPTH];
  logic [PW+1:0]         credit;
  logic                  fire;
  logic                  push;
  logic                  pop;

  // Every accepted read reserves a FIFO slot before its data exists, so a
  // push can never land in a full FIFO.
  assign credit    = {1'b0, occ} + {{(PW+1){1'b0}}, inflight};
  assign req_ready = (credit < (PW+2)'(RESP_DEPTH)) && !rst;
  assign fire      = req_valid && req_ready;

  assign ram_ena  = fire;
  assign ram_we   = fire ? req_we : '0;
  assign ram_addr = req_addr;
  assign ram_din  = req_wdata;

  assign push       = inflight;
  assign pop        = resp_valid && resp_ready;
  assign resp_valid = (occ != '0);
  assign resp_data  = fifo[rd_ptr];
  assign busy       = inflight || (occ != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      occ      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= fire && req_rd;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      occ <= occ + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // Storage is not reset; entries are only visible once occ says they are valid.
  always_ff @(posedge clk) begin
    if (push && !rst) fifo[wr_ptr] <= ram_dout;
  end

endmodule

// File: tb/tb_bytewrite_ram_req_ctrl.sv
// Bench for bytewrite_ram_req_ctrl: behavioural read-first RAM, shadow memory model,
// cycle table for write/read/read-first, and hand sequences for the corner cases.
module tb_bytewrite_ram_req_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_rd;
  logic [3:0]  req_we;
  logic [9:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        ram_ena;
  logic [3:0]  ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_din, ram_dout;
  logic        busy;

  bytewrite_ram_req_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rd(req_rd),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .ram_ena(ram_ena), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- RAM environment (read-first, registered dout) ----------------
  logic [31:0] mem [1024];
  logic [31:0] model [1024];
  always @(posedge clk) begin
    if (ram_ena) begin
      ram_dout <= mem[ram_addr];
      for (int i = 0; i < 4; i++)
        if (ram_we[i]) mem[ram_addr][i*8 +: 8] <= ram_din[i*8 +: 8];
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];
  int          acc_cyc_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_pops = 0;
  int          cyc = 0;
  bit          lat_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle at the falling edge, samples 1 ns later, and updates the
  // model/scoreboard for whatever will transfer on the next rising edge.
  logic acc;
  task automatic step(input logic r, input logic v, input logic rd, input logic [3:0] we,
                      input logic [9:0] addr, input logic [31:0] wd, input logic rr);
    @(negedge clk);
    rst = r; req_valid = v; req_rd = rd; req_we = we; req_addr = addr;
    req_wdata = wd; resp_ready = rr;
    #1;
    cyc++;
    acc = req_valid && req_ready;
    if (dut.inflight && dut.occ == 3'd4) chk("push_into_full", 1, 0);
    if (resp_valid && resp_ready) begin
      n_pops++;
      if (exp_q.size() == 0) chk("unexpected_resp", 1, 0);
      else begin
        chk("resp_data", resp_data, exp_q.pop_front());
        if (lat_chk) chk("resp_latency", 32'(cyc - acc_cyc_q[0]), 2);
        void'(acc_cyc_q.pop_front());
      end
    end
    if (acc) begin
      if (rd) begin
        exp_q.push_back(model[addr]);
        acc_cyc_q.push_back(cyc);
      end
      for (int i = 0; i < 4; i++)
        if (we[i]) model[addr][i*8 +: 8] = wd[i*8 +: 8];
    end
  endtask

  // ---------------- directed cycle table ----------------
  typedef struct {
    logic v; logic rd; logic [3:0] we; logic [9:0] addr; logic [31:0] wd; logic rr;
    logic e_ready; logic e_ena; logic [3:0] e_we; logic e_rv; logic [31:0] e_data; logic e_busy;
  } vec_t;
  vec_t tbl [10];

  int          idx, pops0, nxt, nacc;
  logic [1:0]  wp, rp, wp1, rp1;

  initial begin
    for (int a = 0; a < 1024; a++) begin
      mem[a]   = 32'hC0DE_0000 + 32'(a);
      model[a] = 32'hC0DE_0000 + 32'(a);
    end
    //            v  rd we     addr    wdata          rr  rdy ena we     rv data           busy
    tbl[0] = '{1, 0, 4'hF, 10'h005, 32'h11223344, 1,  1,  1, 4'hF, 0, 32'h0,          0};
    tbl[1] = '{1, 1, 4'h0, 10'h005, 32'h0,        1,  1,  1, 4'h0, 0, 32'h0,          0};
    tbl[2] = '{0, 0, 4'h0, 10'h000, 32'h0,        1,  1,  0, 4'h0, 0, 32'h0,          1};
    tbl[3] = '{0, 0, 4'h0, 10'h000, 32'h0,        1,  1,  0, 4'h0, 1, 32'h11223344,   1};
    tbl[4] = '{1, 1, 4'h5, 10'h005, 32'hAABBCCDD, 1,  1,  1, 4'h5, 0, 32'h0,          0};
    tbl[5] = '{1, 1, 4'h0, 10'h005, 32'h0,        1,  1,  1, 4'h0, 0, 32'h0,          1};
    tbl[6] = '{0, 0, 4'h0, 10'h000, 32'h0,        0,  1,  0, 4'h0, 1, 32'h11223344,   1};
    tbl[7] = '{0, 0, 4'h0, 10'h000, 32'h0,        1,  1,  0, 4'h0, 1, 32'h11223344,   1};
    tbl[8] = '{0, 0, 4'h0, 10'h000, 32'h0,        1,  1,  0, 4'h0, 1, 32'h11BB33DD,   1};
    tbl[9] = '{0, 0, 4'h0, 10'h000, 32'h0,        1,  1,  0, 4'h0, 0, 32'h0,          0};

    rst = 1'b1; req_valid = 0; req_rd = 0; req_we = 0; req_addr = 0; req_wdata = 0;
    resp_ready = 0;
    repeat (2) @(posedge clk);

    // reset state, with a request presented to show it cannot fire
    step(1, 1, 1, 4'hF, 10'h3, 32'h0, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_ram_ena", ram_ena, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_busy", busy, 0);

    // write / read / read-first byte write
    for (int i = 0; i < 10; i++) begin
      step(0, tbl[i].v, tbl[i].rd, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].rr);
      chk($sformatf("tbl%0d_req_ready", i), req_ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_ram_ena", i), ram_ena, tbl[i].e_ena);
      chk($sformatf("tbl%0d_ram_we", i), ram_we, tbl[i].e_we);
      chk($sformatf("tbl%0d_resp_valid", i), resp_valid, tbl[i].e_rv);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      if (tbl[i].e_rv) chk($sformatf("tbl%0d_resp_data", i), resp_data, tbl[i].e_data);
      if (tbl[i].e_ena) begin
        chk($sformatf("tbl%0d_ram_addr", i), ram_addr, tbl[i].addr);
        chk($sformatf("tbl%0d_ram_din", i), ram_din, tbl[i].wd);
      end
    end

    // backpressure: reads to 1..6 with resp_ready low, only 4 fit
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      step(0, idx < 6, 1, 4'h0, 10'(idx + 1), 32'h0, 0);
      if (acc) idx++;
    end
    chk("bp_accepted", idx, 4);
    chk("bp_req_ready_low", req_ready, 0);
    pops0 = n_pops;
    for (int k = 0; k < 24 && (idx < 6 || exp_q.size() != 0 || busy); k++) begin
      step(0, idx < 6, 1, 4'h0, 10'(idx + 1), 32'h0, 1);
      if (acc) idx++;
    end
    chk("bp_all_accepted", idx, 6);
    chk("bp_resp_count", n_pops - pops0, 6);
    chk("bp_queue_empty", exp_q.size(), 0);

    // streaming: back-to-back reads 0..15
    lat_chk = 1;
    for (int k = 0; k < 18; k++) begin
      step(0, k < 16, 1, 4'h0, 10'(k), 32'h0, 1);
      if (k < 16) chk("stream_accept", acc, 1);
      chk("stream_resp_valid", resp_valid, k >= 2);
      chk("stream_occ_le2", dut.occ <= 3'd2, 1);
    end
    lat_chk = 0;
    chk("stream_queue_empty", exp_q.size(), 0);

    // push and pop together at occ=3, three rounds of four pushes each
    nxt = 100;
    for (int rnd = 0; rnd < 3; rnd++) begin
      nacc = 0;
      for (int k = 0; k < 8; k++) begin
        step(0, 1, 1, 4'h0, 10'(nxt), 32'h0, 0);
        if (acc) begin nxt++; nacc++; end
        if (!req_ready) break;
      end
      chk("wrap_fill_accepts", nacc, 4);
      chk("wrap_pre_occ", 32'(dut.occ), 3);
      chk("wrap_pre_inflight", 32'(dut.inflight), 1);
      wp = dut.wr_ptr; rp = dut.rd_ptr;
      wp1 = wp + 2'd1; rp1 = rp + 2'd1;
      step(0, 1, 1, 4'h0, 10'(nxt), 32'h0, 1);
      chk("wrap_no_accept", acc, 0);
      @(posedge clk); #1;
      chk("wrap_post_occ", 32'(dut.occ), 3);
      chk("wrap_wr_ptr", 32'(dut.wr_ptr), 32'(wp1));
      chk("wrap_rd_ptr", 32'(dut.rd_ptr), 32'(rp1));
      for (int k = 0; k < 10 && busy; k++) step(0, 0, 0, 4'h0, 10'h0, 32'h0, 1);
      chk("wrap_drained", busy, 0);
    end
    chk("wrap_queue_empty", exp_q.size(), 0);

    // reset while a read is in flight
    step(0, 1, 1, 4'h0, 10'h007, 32'h0, 1);
    chk("mid_rst_accept", acc, 1);
    step(1, 1, 1, 4'hF, 10'h009, 32'hDEADBEEF, 1);
    chk("mid_rst_req_ready", req_ready, 0);
    chk("mid_rst_ram_ena", ram_ena, 0);
    @(posedge clk); #1;
    chk("mid_rst_resp_valid", resp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    exp_q.delete();
    acc_cyc_q.delete();
    pops0 = n_pops;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 4'h0, 10'h0, 32'h0, 1);
      chk("post_rst_resp_valid", resp_valid, 0);
      chk("post_rst_busy", busy, 0);
    end
    step(0, 1, 1, 4'h0, 10'h007, 32'h0, 1);
    chk("post_rst_accept", acc, 1);
    step(0, 0, 0, 4'h0, 10'h0, 32'h0, 1);
    step(0, 0, 0, 4'h0, 10'h0, 32'h0, 1);
    chk("post_rst_resp_count", n_pops - pops0, 1);
    chk("post_rst_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bytewrite_ram_req_ctrl.md
Name: bytewrite_ram_req_ctrl

Overview:
- Request/response front end for the single-port byte-write RAM (NUM_COL byte lanes, read-first, 1-cycle registered read).
- Accepts valid/ready requests from a master and drives the RAM port (ena/we/addr/din).
- Captures the RAM's registered dout for read requests into a response FIFO, so master backpressure never loses read data.
- Sits directly upstream of the RAM and owns its port exclusively.

Parameters:
- NUM_COL, 4, number of byte lanes
- COL_WIDTH, 8, bits per lane
- ADDR_WIDTH, 10, RAM address width
- DATA_WIDTH, NUM_COL*COL_WIDTH, data width
- RESP_DEPTH, 4, response FIFO entries; must be a power of 2 and at least 2

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_rd  in  1  request returns a response (read data)
- req_we  in  NUM_COL  per-lane write enables
- req_addr  in  ADDR_WIDTH  word address
- req_wdata  in  DATA_WIDTH  write data
- resp_valid  out  1  response FIFO non-empty
- resp_ready  in  1  master consumes response
- resp_data  out  DATA_WIDTH  FIFO head data
- ram_ena  out  1  to RAM ena
- ram_we  out  NUM_COL  to RAM we
- ram_addr  out  ADDR_WIDTH  to RAM addr
- ram_din  out  DATA_WIDTH  to RAM din
- ram_dout  in  DATA_WIDTH  from RAM dout (registered in RAM)
- busy  out  1  in-flight read or FIFO non-empty

Behaviour:
- Clocking and reset:
  - Single clock; reset is synchronous and active-high.
  - Reset clears: inflight=0, occ=0, wr_ptr=0, rd_ptr=0.
  - Outputs during/after reset: resp_valid=0, busy=0. resp_data reflects FIFO entry 0 (don't-care while resp_valid=0).
- Credit and acceptance:
  - credit = occ + inflight, computed from registers only.
  - req_ready = (credit < RESP_DEPTH) && !rst.
  - No combinational path from resp_ready or req_valid to req_ready.
- Fire:
  - fire = req_valid && req_ready.
  - RAM port is combinational from the request: ram_ena=fire; ram_we = fire ? req_we : 0; ram_addr=req_addr; ram_din=req_wdata.
- Write-only and no-op requests:
  - fire with req_rd=0 writes the enabled lanes and produces no response.
  - fire with req_rd=0 and req_we=0 is a legal no-op (ena pulse only).
- Reads:
  - fire with req_rd=1 sets inflight=1 for the next cycle.
  - The RAM is read-first: the data returned is the pre-write word, even if the same request also writes lanes.
- Capture:
  - A cycle with inflight=1 pushes ram_dout into fifo[wr_ptr].
  - wr_ptr increments mod RESP_DEPTH.
  - inflight next = (fire && req_rd).
- Pop:
  - resp_valid && resp_ready pops fifo[rd_ptr]; rd_ptr increments mod RESP_DEPTH.
- Occupancy update:
  - occ_next = occ + push - pop.
  - Simultaneous push and pop leaves occ unchanged.
  - Push into a full FIFO is impossible by the credit rule; the bench asserts it never occurs.
- Outputs: resp_valid = (occ != 0); resp_data = fifo[rd_ptr]; busy = inflight || (occ != 0).
- Latency and throughput:
  - Read accepted at cycle T → RAM dout valid at T+1 → resp_valid at T+2.
  - Sustained one read per cycle when resp_ready=1.
- Ordering: responses are returned strictly in request order.
- Pointer width: log2(RESP_DEPTH); occ width log2(RESP_DEPTH)+1. Wrap is natural power-of-2 overflow.
- Reset mid-operation:
  - An in-flight read is discarded and FIFO contents are abandoned.
  - ram_ena is forced to 0 during reset because req_ready=0.

Test Plan:
- Write, then read, same address: reset, write addr 0x005 we=4'hF data 0x11223344, then read addr 0x005 with resp_ready=1 → resp_valid exactly 2 cycles after the read accept, resp_data=0x11223344.
- Byte write plus read-first: write 0x005 we=4'b0101 data 0xAABBCCDD, with req_rd=1 on that same request → response returns old word 0x11223344; a following read returns 0x11BB33DD.
- Backpressure: hold resp_ready=0 and issue reads to addrs 1..6 → exactly 4 accepted (req_ready drops when credit=4). Release resp_ready → 4 responses in address order, then the remaining reads are accepted.
- Streaming: resp_ready=1 and back-to-back reads to addrs 0..15 → req_ready stays 1, one response per cycle, in order, 2-cycle latency, occ never exceeds 2.
- Simultaneous push and pop at occ=RESP_DEPTH-1 → occ is unchanged and the pointers wrap correctly across 3 full FIFO cycles.
- Reset mid-read: accept a read, assert rst the next cycle → resp_valid=0, busy=0, no stale response after rst deasserts; the next read returns correct data.
